a78_save_uploader: RTL and testbench



---
 rtl/a78_save_uploader_pkg.sv | 33 +++
 rtl/a78_save_uploader_hdr_rom.sv | 29 ++
 rtl/a78_save_uploader.sv | 168 ++++++++++++++++
 tb/tb_a78_save_uploader.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/a78_save_uploader_pkg.sv
// Shared types for the A78 save-RAM upload path.
// Header constants exist only when SAVE_HEADER_EN is defined.
package a78_pkg;

    typedef enum logic [7:0] {
        SAVE_NONE    = 8'h00,
        SAVE_HSC     = 8'h01,
        SAVE_SAVEKEY = 8'h02
    } save_type_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WAIT,
        ST_DATA
    } state_e;

    typedef enum logic [1:0] {
        SEL_HDR,
        SEL_RAM,
        SEL_FF
    } sel_e;

`ifdef SAVE_HEADER_EN
    localparam logic [55:0] HDR_MAGIC   = 56'h41_37_38_53_41_56_45; // "A78SAVE"
    localparam logic [7:0]  HDR_VERSION = 8'h01;

    function automatic logic [7:0] magic_byte(input logic [2:0] idx);
        return HDR_MAGIC[(6 - int'(idx)) * 8 +: 8];
    endfunction
`endif

endpackage

// File: rtl/a78_save_uploader_hdr_rom.sv
// Combinational lookup of the fixed save-file header bytes.
// Only compiled when SAVE_HEADER_EN is defined.
`ifdef SAVE_HEADER_EN
module a78_save_hdr_rom
    import a78_pkg::*;
(
    input  logic [7:0]  idx,
    input  logic [7:0]  save_type,
    input  logic [15:0] pay_len,
    output logic [7:0]  hdr_byte
);

    always_comb begin
        hdr_byte = '0;
        if (idx < 8'd7) begin
            hdr_byte = magic_byte(idx[2:0]);
        end else begin
            case (idx)
                8'd7:    hdr_byte = HDR_VERSION;
                8'd8:    hdr_byte = save_type;
                8'd10:   hdr_byte = pay_len[15:8];
                8'd11:   hdr_byte = pay_len[7:0];
                default: hdr_byte = '0;
            endcase
        end
    end

endmodule
`endif

// File: rtl/a78_save_uploader.sv
// Answers HPS ioctl upload reads with header/save-RAM bytes and tracks save dirtiness.
// Optional file header enabled by defining SAVE_HEADER_EN.
module a78_save_uploader
    import a78_pkg::*;
#(
    parameter int unsigned RAM_AW  = 11,
    parameter int unsigned HDR_LEN = 16
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ioctl_upload,
    input  logic              ioctl_rd,
    input  logic [24:0]       ioctl_addr,
    output logic [7:0]        ioctl_din,
    input  logic [7:0]        save_type,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_rd,
    input  logic [7:0]        ram_q,
    input  logic              ram_wr_mon,
    output logic [15:0]       upload_len,
    output logic              upload_busy,
    output logic              upload_done,
    output logic              save_dirty
);

`ifdef SAVE_HEADER_EN
    localparam bit HDR_EN = 1'b1;
`else
    localparam bit HDR_EN = 1'b0;
`endif
    localparam logic [24:0] PAY_LEN   = 25'(2 ** RAM_AW);
    localparam logic [24:0] HDR_BYTES = HDR_EN ? 25'(HDR_LEN) : '0;

    state_e            state_q, state_d;
    sel_e              sel_q, sel_d, sel_new;
    logic [24:0]       addr_q, addr_d;
    logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
    logic              ram_rd_q, ram_rd_d;
    logic [7:0]        din_q, din_d;
    logic              busy_q, busy_d;
    logic              seen_q, seen_d;
    logic              done_q, done_d;
    logic              dirty_q, dirty_d;
    logic              upload_q;
    logic [24:0]       file_len;
    logic              deliver, last_addr, fall;

    assign file_len   = (save_type == SAVE_NONE) ? '0 : PAY_LEN + HDR_BYTES;
    assign upload_len = file_len[15:0];
    assign last_addr  = (file_len != '0) && (addr_q == file_len - 25'd1);
    assign fall       = upload_q & ~ioctl_upload;

`ifdef SAVE_HEADER_EN
    logic [7:0] hdr_byte;

    a78_save_hdr_rom u_hdr_rom (
        .idx      (addr_q[7:0]),
        .save_type(save_type),
        .pay_len  (PAY_LEN[15:0]),
        .hdr_byte (hdr_byte)
    );
`endif

    always_comb begin
        sel_new = SEL_RAM;
        if (save_type == SAVE_NONE || ioctl_addr >= file_len) begin
            sel_new = SEL_FF;
`ifdef SAVE_HEADER_EN
        end else if (ioctl_addr < HDR_BYTES) begin
            sel_new = SEL_HDR;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        addr_d     = addr_q;
        ram_addr_d = ram_addr_q;
        ram_rd_d   = 1'b0;
        din_d      = din_q;
        seen_d     = seen_q;
        deliver    = 1'b0;

        // A new strobe preempts any pending fetch, so the RAM read address is issued from it directly.
        if (ioctl_upload && ioctl_rd) begin
            addr_d  = ioctl_addr;
            sel_d   = sel_new;
            state_d = ST_ADDR;
            if (sel_new == SEL_RAM) begin
                ram_addr_d = RAM_AW'(ioctl_addr - HDR_BYTES);
                ram_rd_d   = 1'b1;
            end
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_ADDR: begin
                    if (sel_q == SEL_RAM) begin
                        state_d = ST_WAIT;
                    end else begin
`ifdef SAVE_HEADER_EN
                        din_d = (sel_q == SEL_HDR) ? hdr_byte : 8'hFF;
`else
                        din_d = 8'hFF;
`endif
                        deliver = 1'b1;
                        state_d = ST_DATA;
                    end
                end
                ST_WAIT: begin
                    din_d   = ram_q;
                    deliver = 1'b1;
                    state_d = ST_DATA;
                end
                ST_DATA: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end

        if (deliver && last_addr) seen_d = 1'b1;
        done_d = fall & seen_q;
        if (fall) seen_d = 1'b0;
        busy_d = (state_d == ST_ADDR) || (state_d == ST_WAIT);

        dirty_d = dirty_q;
        if (ram_wr_mon && save_type != SAVE_NONE) begin
            dirty_d = 1'b1;
        end else if (done_q) begin
            dirty_d = 1'b0;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            sel_q      <= SEL_FF;
            addr_q     <= '0;
            ram_addr_q <= '0;
            ram_rd_q   <= 1'b0;
            din_q      <= 8'hFF;
            busy_q     <= 1'b0;
            seen_q     <= 1'b0;
            done_q     <= 1'b0;
            dirty_q    <= 1'b0;
            upload_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            addr_q     <= addr_d;
            ram_addr_q <= ram_addr_d;
            ram_rd_q   <= ram_rd_d;
            din_q      <= din_d;
            busy_q     <= busy_d;
            seen_q     <= seen_d;
            done_q     <= done_d;
            dirty_q    <= dirty_d;
            upload_q   <= ioctl_upload;
        end
    end

    assign ioctl_din   = din_q;
    assign ram_addr    = ram_addr_q;
    assign ram_rd      = ram_rd_q;
    assign upload_busy = busy_q;
    assign upload_done = done_q;
    assign save_dirty  = dirty_q;

endmodule

// File: tb/tb_a78_save_uploader.sv
// Randomized self-checking bench for a78_save_uploader against a file-level byte model.
// Honours SAVE_HEADER_EN the same way as the design.
module tb_a78_save_uploader;

    localparam int unsigned RAM_AW = 11;
    localparam int unsigned PAY    = 2048;
`ifdef SAVE_HEADER_EN
    localparam int unsigned HDR = 16;
`else
    localparam int unsigned HDR = 0;
`endif

    logic              clk_sys = 1'b0;
    logic              reset_n;
    logic              ioctl_upload;
    logic              ioctl_rd;
    logic [24:0]       ioctl_addr;
    logic [7:0]        ioctl_din;
    logic [7:0]        save_type;
    logic [RAM_AW-1:0] ram_addr;
    logic              ram_rd;
    logic [7:0]        ram_q;
    logic              ram_wr_mon;
    logic [15:0]       upload_len;
    logic              upload_busy;
    logic              upload_done;
    logic              save_dirty;

    int unsigned n_checks = 0;
    int unsigned n_err    = 0;
    logic [7:0]  mem [PAY];
    logic [7:0]  last_exp;

    a78_save_uploader #(.RAM_AW(RAM_AW), .HDR_LEN(16)) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .ioctl_upload(ioctl_upload),
        .ioctl_rd    (ioctl_rd),
        .ioctl_addr  (ioctl_addr),
        .ioctl_din   (ioctl_din),
        .save_type   (save_type),
        .ram_addr    (ram_addr),
        .ram_rd      (ram_rd),
        .ram_q       (ram_q),
        .ram_wr_mon  (ram_wr_mon),
        .upload_len  (upload_len),
        .upload_busy (upload_busy),
        .upload_done (upload_done),
        .save_dirty  (save_dirty)
    );

    always #5 clk_sys = ~clk_sys;

    // Synchronous-read save RAM: data one cycle after ram_rd.
    always @(posedge clk_sys) if (ram_rd) ram_q <= mem[ram_addr];

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int unsigned file_len(input logic [7:0] st);
        return (st == 8'd0) ? 0 : PAY + HDR;
    endfunction

    function automatic logic [7:0] exp_byte(input int unsigned a, input logic [7:0] st);
        logic [7:0] magic [7];
        magic = '{8'h41, 8'h37, 8'h38, 8'h53, 8'h41, 8'h56, 8'h45};
        if (st == 8'd0 || a >= file_len(st)) return 8'hFF;
        if (a < HDR) begin
            if (a < 7) return magic[a];
            case (a)
                7:       return 8'h01;
                8:       return st;
                10:      return 8'(PAY >> 8);
                11:      return 8'(PAY & 255);
                default: return 8'h00;
            endcase
        end
        return mem[a - HDR];
    endfunction

    task automatic do_read(input int unsigned a, input string tag);
        logic [7:0] e;
        logic       pay;
        e   = exp_byte(a, save_type);
        pay = (save_type != 8'd0) && (a >= HDR) && (a < file_len(save_type));
        @(negedge clk_sys);
        ioctl_rd   = 1'b1;
        ioctl_addr = 25'(a);
        @(negedge clk_sys);
        ioctl_rd = 1'b0;
        chk_eq({tag, "_ramrd"}, 32'(ram_rd), 32'(pay));
        chk_eq({tag, "_busy"}, 32'(upload_busy), 32'd1);
        if (pay) chk_eq({tag, "_ramaddr"}, 32'(ram_addr), a - HDR);
        repeat (pay ? 2 : 1) @(negedge clk_sys);
        chk_eq({tag, "_din"}, 32'(ioctl_din), 32'(e));
        last_exp = e;
        repeat (3) @(negedge clk_sys);
    endtask

    task automatic drop_upload(output int unsigned pulses);
        @(negedge clk_sys);
        ioctl_upload = 1'b0;
        pulses = 0;
        repeat (4) begin
            @(negedge clk_sys);
            if (upload_done) pulses++;
        end
    endtask

    task automatic wr_pulse();
        @(negedge clk_sys);
        ram_wr_mon = 1'b1;
        @(negedge clk_sys);
        ram_wr_mon = 1'b0;
    endtask

    initial begin
        int unsigned pulses;
        for (int i = 0; i < int'(PAY); i++) mem[i] = 8'($urandom);
        mem[5]   = 8'h5A;
        mem[100] = 8'h11;
        mem[200] = 8'h22;
        reset_n      = 1'b0;
        ioctl_upload = 1'b0;
        ioctl_rd     = 1'b0;
        ioctl_addr   = '0;
        save_type    = 8'd1;
        ram_wr_mon   = 1'b0;
        last_exp     = 8'hFF;

        repeat (3) @(negedge clk_sys);
        chk_eq("rst_din", 32'(ioctl_din), 32'hFF);
        chk_eq("rst_ramaddr", 32'(ram_addr), 32'd0);
        chk_eq("rst_ramrd", 32'(ram_rd), 32'd0);
        chk_eq("rst_busy", 32'(upload_busy), 32'd0);
        chk_eq("rst_done", 32'(upload_done), 32'd0);
        chk_eq("rst_dirty", 32'(save_dirty), 32'd0);
        reset_n      = 1'b1;
        ioctl_upload = 1'b1;
        @(negedge clk_sys);
        chk_eq("len_hsc", 32'(upload_len), PAY + HDR);

        // Directed bytes: header fields, known payload byte, first out-of-range address.
        do_read(0, "a0");
        do_read(8, "a8");
        do_read(10, "a10");
        @(negedge clk_sys);
        ioctl_rd   = 1'b1;
        ioctl_addr = 25'(HDR + 5);
        @(negedge clk_sys);
        ioctl_rd = 1'b0;
        chk_eq("p5_ramrd_t1", 32'(ram_rd), 32'd1);
        chk_eq("p5_ramaddr", 32'(ram_addr), 32'd5);
        @(negedge clk_sys);
        chk_eq("p5_ramrd_t2", 32'(ram_rd), 32'd0);
        @(negedge clk_sys);
        chk_eq("p5_din_t3", 32'(ioctl_din), 32'h5A);
        repeat (3) @(negedge clk_sys);
        do_read(PAY + HDR, "oor");

        for (int i = 0; i < 60; i++) begin
            save_type = 8'($urandom_range(2, 1));
            do_read($urandom_range(PAY + HDR + 8, 0), "rnd");
        end
        save_type = 8'd1;

        wr_pulse();
        chk_eq("dirty_set", 32'(save_dirty), 32'd1);
        for (int a = 0; a < int'(PAY + HDR); a++) do_read(a, "full");
        drop_upload(pulses);
        chk_eq("full_done", pulses, 32'd1);
        chk_eq("full_dirty_clr", 32'(save_dirty), 32'd0);

        ioctl_upload = 1'b1;
        save_type    = 8'd0;
        @(negedge clk_sys);
        chk_eq("len_none", 32'(upload_len), 32'd0);
        wr_pulse();
        @(negedge clk_sys);
        chk_eq("none_dirty", 32'(save_dirty), 32'd0);
        do_read(0, "none0");
        do_read(HDR + 5, "none5");

        save_type = 8'd2;
        wr_pulse();
        chk_eq("dirty_set2", 32'(save_dirty), 32'd1);
        for (int a = 0; a < 10; a++) do_read(a, "part");
        drop_upload(pulses);
        chk_eq("part_done", pulses, 32'd0);
        chk_eq("part_dirty", 32'(save_dirty), 32'd1);

        // Back-to-back strobes: only the second address may be delivered.
        ioctl_upload = 1'b1;
        repeat (2) @(negedge clk_sys);
        @(negedge clk_sys);
        ioctl_rd   = 1'b1;
        ioctl_addr = 25'(HDR + 100);
        @(negedge clk_sys);
        ioctl_addr = 25'(HDR + 200);
        @(negedge clk_sys);
        ioctl_rd = 1'b0;
        @(negedge clk_sys);
        chk_eq("coll_hold", 32'(ioctl_din), 32'(last_exp));
        @(negedge clk_sys);
        chk_eq("coll_second", 32'(ioctl_din), 32'h22);
        repeat (3) @(negedge clk_sys);

        // Reset during a payload fetch.
        @(negedge clk_sys);
        ioctl_rd   = 1'b1;
        ioctl_addr = 25'(HDR + 300);
        @(negedge clk_sys);
        ioctl_rd = 1'b0;
        reset_n  = 1'b0;
        @(negedge clk_sys);
        chk_eq("mrst_din", 32'(ioctl_din), 32'hFF);
        chk_eq("mrst_ramrd", 32'(ram_rd), 32'd0);
        chk_eq("mrst_ramaddr", 32'(ram_addr), 32'd0);
        chk_eq("mrst_busy", 32'(upload_busy), 32'd0);
        chk_eq("mrst_done", 32'(upload_done), 32'd0);
        chk_eq("mrst_dirty", 32'(save_dirty), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk_sys);
        chk_eq("mrst_nocap", 32'(ioctl_din), 32'hFF);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
